seq_divider: RTL and testbench



---
 rtl/seq_divider.sv | 130 +++++++++++++
 tb/tb_seq_divider.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock.
// Start accepted in IDLE or DONE; quotient/remainder/div_by_zero update only on entry to DONE.
module seq_divider #(
    parameter int unsigned dw = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [dw-1:0] dividend,
    input  logic [dw-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [dw-1:0] quotient,
    output logic [dw-1:0] remainder,
    output logic          div_by_zero
);

    localparam int unsigned CW = $clog2(dw);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [dw-1:0] a_q, a_d;
    logic [dw-1:0] b_q, b_d;
    // The stored partial remainder is always below the divisor, so its top bit is
    // implicitly zero; the full dw+1-bit value exists only as p_shift below.
    logic [dw-1:0] p_q, p_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [dw-1:0] quotient_q, quotient_d;
    logic [dw-1:0] remainder_q, remainder_d;
    logic          div_by_zero_q, div_by_zero_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [dw:0]   p_shift;
    logic [dw-1:0] p_sub;
    logic [dw-1:0] p_step;
    logic [dw-1:0] a_next;
    logic          ge;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        p_shift = {p_q, a_q[dw-1]};
        ge      = (p_shift >= {1'b0, b_q});
        p_sub   = p_shift[dw-1:0] - b_q;
        p_step  = ge ? p_sub : p_shift[dw-1:0];
        a_next  = {a_q[dw-2:0], ge};
    end

    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        p_d           = p_q;
        cnt_d         = cnt_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    a_d   = dividend;
                    b_d   = divisor;
                    p_d   = '0;
                    cnt_d = '0;
                    if (divisor != '0) begin
                        state_d = S_RUN;
                    end else begin
                        state_d       = S_DONE;
                        quotient_d    = '1;
                        remainder_d   = dividend;
                        div_by_zero_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                a_d   = a_next;
                p_d   = p_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(dw - 1)) begin
                    state_d       = S_DONE;
                    quotient_d    = a_next;
                    remainder_d   = p_step;
                    div_by_zero_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            a_q           <= '0;
            b_q           <= '0;
            p_q           <= '0;
            cnt_q         <= '0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            p_q           <= p_d;
            cnt_q         <= cnt_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected results queued at start, checked on done.
module tb_seq_divider;

    localparam int unsigned DW = 8;

    typedef struct packed {
        logic [DW-1:0] q;
        logic [DW-1:0] r;
        logic          dz;
    } exp_t;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [DW-1:0] dividend;
    logic [DW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [DW-1:0] remainder;
    logic          div_by_zero;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   done_cnt  = 0;

    seq_divider #(.dw(DW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the first negedge after the sampling edge.
    task automatic start_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit push);
        exp_t e;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        if (b == '0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
            e.q  = DW'(a / b);
            e.r  = DW'(a % b);
            e.dz = 1'b0;
        end
        if (push) sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(input int n0, output int lat, output int bcyc);
        int n;
        n    = n0;
        bcyc = 0;
        while (!done && n < 40) begin
            bcyc += int'(busy);
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(done), 1);
        lat = n;
    endtask

    // Monitor: result check on done, busy/done exclusivity every active cycle.
    always @(negedge clk) begin
        if (reset_n && (busy || done))
            chk("busy_done_excl", 32'(busy && done), 0);
        if (reset_n && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(sb.size()), 1);
            end else begin
                mon_e = sb.pop_front();
                chk("quotient", 32'(quotient), 32'(mon_e.q));
                chk("remainder", 32'(remainder), 32'(mon_e.r));
                chk("div_by_zero", 32'(div_by_zero), 32'(mon_e.dz));
            end
        end
    end

    initial begin
        int lat, bc, saved;
        logic [DW-1:0] ra, rb;
        reset_n  = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_q", 32'(quotient), 0);
        chk("rst_r", 32'(remainder), 0);
        chk("rst_dz", 32'(div_by_zero), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Basic 100/7 with latency and busy length
        start_op(8'd100, 8'd7, 1'b1);
        wait_done(0, lat, bc);
        chk("lat_100_7", 32'(lat), 8);
        chk("busy_100_7", 32'(bc), 8);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 0);

        // Edge operands
        start_op(8'd255, 8'd1, 1'b1);   wait_done(0, lat, bc);
        start_op(8'd5, 8'd9, 1'b1);     wait_done(0, lat, bc);
        start_op(8'd0, 8'd3, 1'b1);     wait_done(0, lat, bc);
        start_op(8'd255, 8'd255, 1'b1); wait_done(0, lat, bc);
        repeat (3) @(negedge clk);
        chk("hold_q_idle", 32'(quotient), 1);
        chk("hold_r_idle", 32'(remainder), 0);

        // Divide by zero then a normal op
        start_op(8'd37, 8'd0, 1'b1);
        wait_done(0, lat, bc);
        chk("lat_dz", 32'(lat), 0);
        chk("busy_dz", 32'(bc), 0);
        @(negedge clk);
        start_op(8'd20, 8'd4, 1'b1);
        wait_done(0, lat, bc);
        chk("lat_20_4", 32'(lat), 8);
        @(negedge clk);

        // start pulses during RUN must be ignored
        start_op(8'd200, 8'd3, 1'b1);
        @(negedge clk);
        start_op(8'd9, 8'd9, 1'b0);
        @(negedge clk);
        @(negedge clk);
        start_op(8'd9, 8'd9, 1'b0);
        chk("ign_busy", 32'(busy), 1);
        chk("ign_hold_q", 32'(quotient), 5);
        wait_done(5, lat, bc);
        chk("lat_ignored", 32'(lat), 8);
        @(negedge clk);

        // Reset mid-RUN (before the 4th step)
        start_op(8'd100, 8'd7, 1'b1);
        repeat (3) @(negedge clk);
        saved   = done_cnt;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_q", 32'(quotient), 0);
        chk("mid_rst_r", 32'(remainder), 0);
        chk("mid_rst_dz", 32'(div_by_zero), 0);
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("mid_rst_no_done", 32'(done_cnt), 32'(saved));
        start_op(8'd50, 8'd6, 1'b1);
        wait_done(0, lat, bc);
        chk("lat_50_6", 32'(lat), 8);
        @(negedge clk);

        // Back-to-back: new start during DONE
        start_op(8'd100, 8'd7, 1'b1);
        wait_done(0, lat, bc);
        start_op(8'd81, 8'd9, 1'b1);
        chk("b2b_done_once", 32'(done), 0);
        chk("b2b_hold_q", 32'(quotient), 14);
        chk("b2b_busy", 32'(busy), 1);
        wait_done(0, lat, bc);
        chk("lat_b2b", 32'(lat), 8);

        // Randomized sweep, chained back-to-back
        for (int i = 0; i < 1000; i++) begin
            ra = DW'($urandom_range(0, 255));
            rb = ($urandom_range(0, 15) == 0) ? '0 : DW'($urandom_range(1, 255));
            start_op(ra, rb, 1'b1);
            wait_done(0, lat, bc);
            chk("lat_rand", 32'(lat), (rb == '0) ? 0 : 8);
        end
        @(negedge clk);
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
